// File: rtl/i2s_capture_ctrl.sv
// ---------------------------------------------------------------------------
// i2s_capture_ctrl
//
// Power sequencer and sample buffer for the I2S microphone front-end.
// It releases the front-end from reset and waits for it to settle. It then
// throws away the start-up transient samples and buffers good samples in a
// small first-word-fall-through FIFO. The FIFO drains over a valid/ready
// stream.
// A watchdog trips into ERROR if the front-end stops producing samples. A
// saturating counter records samples lost because the FIFO was full.
//
// Ports
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   start_i        1-cycle pulse, begin capture (honoured in IDLE / ERROR)
//   stop_i         1-cycle pulse, end capture (honoured in WAKE/DISCARD/RUN)
//   fe_rst_n_o     active-low reset to the I2S front-end
//   fe_sample_i    16-bit sample word from the front-end
//   fe_valid_i     1-cycle sample strobe, synchronous to clk_i
//   m_data_o       output sample (head of FIFO, registered)
//   m_valid_o      output valid
//   m_ready_i      downstream ready
//   running_o      high in RUN
//   busy_o         high in WAKE, DISCARD, RUN, DRAIN
//   err_timeout_o  sticky stall flag
//   ovf_count_o    samples dropped on a full FIFO, saturating
//   state_o        IDLE=0 WAKE=1 DISCARD=2 RUN=3 DRAIN=4 ERROR=5
// ---------------------------------------------------------------------------
module i2s_capture_ctrl #(
  parameter int WAKE_CYCLES     = 1000000,
  parameter int DISCARD_SAMPLES = 4096,
  parameter int FIFO_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES  = 12800
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stop_i,
  output logic        fe_rst_n_o,
  input  logic [15:0] fe_sample_i,
  input  logic        fe_valid_i,
  output logic [15:0] m_data_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic        running_o,
  output logic        busy_o,
  output logic        err_timeout_o,
  output logic [15:0] ovf_count_o,
  output logic [2:0]  state_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [31:0] WAKE_LAST    = 32'(WAKE_CYCLES - 1);
  localparam logic [31:0] DISCARD_LAST = 32'(DISCARD_SAMPLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAKE    = 3'd1,
    ST_DISCARD = 3'd2,
    ST_RUN     = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  // Shared cycle counter: wake settle time in WAKE, watchdog in DISCARD/RUN.
  logic [31:0]   cyc_q, cyc_d;
  logic [31:0]   disc_q, disc_d;
  logic          err_q, err_d;
  logic [15:0]   ovf_q, ovf_d;
  logic          fe_rst_n_q, running_q, busy_q;

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;

  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          rd_en_s;
  logic          wr_req_s;
  logic          wr_en_s;
  logic          flush_s;
  logic          ovf_clr_s;
  logic          start_ok_s;

  // FIFO status from the registered pointers; the extra MSB separates full from empty.
  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en_s      = m_valid_q & m_ready_i;
  // stop has priority over start when both arrive together.
  assign start_ok_s   = start_i & ~stop_i;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en_s      = wr_req_s & (~fifo_full_s | rd_en_s);

  // Next-state, counter and control decode for the capture sequencer.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    disc_d    = disc_q;
    err_d     = err_q;
    ovf_clr_s = 1'b0;
    wr_req_s  = 1'b0;
    flush_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_d   = ST_WAKE;
          cyc_d     = 32'd0;
          ovf_clr_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAKE: begin
        if (stop_i) begin
          state_d = ST_DRAIN;
        end else if (cyc_q == WAKE_LAST) begin
          state_d = ST_DISCARD;
          cyc_d   = 32'd0;
          disc_d  = 32'd0;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      ST_DISCARD: begin
        if (stop_i) begin
          state_d = ST_DRAIN;
        end else if (fe_valid_i) begin
          cyc_d = 32'd0;
          // The final transient sample is dropped here as well.
          if (disc_q == DISCARD_LAST) begin
            state_d = ST_RUN;
            disc_d  = 32'd0;
          end else begin
            disc_d = disc_q + 32'd1;
          end
        end else if (cyc_q == TIMEOUT_LAST) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
          flush_s = 1'b1;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_DRAIN;
        end else if (fe_valid_i) begin
          wr_req_s = 1'b1;
          cyc_d    = 32'd0;
        end else if (cyc_q == TIMEOUT_LAST) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
          flush_s = 1'b1;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_ERROR: begin
        if (start_ok_s) begin
          state_d = ST_WAKE;
          cyc_d   = 32'd0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_ERROR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Overflow counter: cleared on a fresh capture, saturates at all-ones.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr_s) begin
      ovf_d = 16'd0;
    end else if (wr_req_s && fifo_full_s && !rd_en_s && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO pointer update and output-register refill.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (flush_s) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      m_valid_d = 1'b0;
      m_data_d  = m_data_q;
    end else begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en_s};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en_s};
      // Compare against the pre-write pointer so a new entry shows up one
      // cycle after it lands; the head slot is then already in memory.
      m_valid_d = (wr_ptr_q != rd_ptr_d);
      if (m_valid_d) begin
        m_data_d = mem_q[rd_ptr_d[AW-1:0]];
      end else begin
        m_data_d = m_data_q;
      end
    end
  end

  // Sequencer state, counters and registered status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cyc_q      <= 32'd0;
      disc_q     <= 32'd0;
      err_q      <= 1'b0;
      ovf_q      <= 16'd0;
      fe_rst_n_q <= 1'b0;
      running_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      disc_q     <= disc_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      fe_rst_n_q <= (state_d == ST_WAKE) || (state_d == ST_DISCARD) ||
                    (state_d == ST_RUN);
      running_q  <= (state_d == ST_RUN);
      busy_q     <= (state_d != ST_IDLE) && (state_d != ST_ERROR);
    end
  end

  // FIFO pointers and the registered stream outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= 16'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers mark them empty.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= fe_sample_i;
    end
  end

  assign fe_rst_n_o    = fe_rst_n_q;
  assign m_data_o      = m_data_q;
  assign m_valid_o     = m_valid_q;
  assign running_o     = running_q;
  assign busy_o        = busy_q;
  assign err_timeout_o = err_q;
  assign ovf_count_o   = ovf_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2s_capture_ctrl
//
// Scoreboard bench for i2s_capture_ctrl. A sample is pushed to exp_q when the
// bench drives it and expects the FIFO to accept it. A negedge monitor pops
// one entry per stream transfer and compares it with m_data. Scenario tasks
// check state and status outputs inline.
// ---------------------------------------------------------------------------
module tb_i2s_capture_ctrl;

  localparam int WAKE  = 20;
  localparam int DISC  = 3;
  localparam int DEPTH = 8;
  localparam int TMO   = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        fe_rst_n;
  logic [15:0] fe_sample;
  logic        fe_valid;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        running;
  logic        busy;
  logic        err_timeout;
  logic [15:0] ovf_count;
  logic [2:0]  state;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] next_val;
  logic        hold_v = 1'b0;
  logic [15:0] hold_d = 16'd0;

  i2s_capture_ctrl #(
    .WAKE_CYCLES(WAKE), .DISCARD_SAMPLES(DISC),
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .fe_rst_n_o(fe_rst_n), .fe_sample_i(fe_sample), .fe_valid_i(fe_valid),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .running_o(running), .busy_o(busy), .err_timeout_o(err_timeout),
    .ovf_count_o(ovf_count), .state_o(state)
  );

  always #5 clk = ~clk;

  // Stream monitor: pops the scoreboard on each transfer and checks hold stability.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v && m_valid) begin
        total++;
        if (m_data !== hold_d) begin
          bad++;
          $display("FAIL stall_stable m_data=%h held=%h", m_data, hold_d);
        end
      end
      if (m_valid && m_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out m_data=%h expected=none", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            bad++;
            $display("FAIL stream_data m_data=%h expected=%h", m_data, e);
          end
        end
      end
      hold_v <= m_valid && !m_ready;
      hold_d <= m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fe_valid strobe with a fresh value; acc says whether it should be buffered.
  task automatic send(input bit acc, input int gap);
    fe_sample = next_val;
    fe_valid  = 1'b1;
    if (acc) exp_q.push_back(next_val);
    next_val  = next_val + 16'd1;
    tick();
    fe_valid  = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; fe_valid = 1'b0;
    fe_sample = 16'd0; m_ready = 1'b1; next_val = 16'd1;
    #12;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
    total++; if (fe_rst_n !== 1'b0) begin bad++; $display("FAIL rst_fe_rst_n got=%b exp=0", fe_rst_n); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
    total++; if (m_data !== 16'd0) begin bad++; $display("FAIL rst_m_data got=%h exp=0", m_data); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL rst_running got=%b exp=0", running); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_timeout); end
    total++; if (ovf_count !== 16'd0) begin bad++; $display("FAIL rst_ovf got=%0d exp=0", ovf_count); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_wake_discard();
    m_ready = 1'b1;
    pulse_start();
    total++; if (fe_rst_n !== 1'b1) begin bad++; $display("FAIL wake_fe_rst_n got=%b exp=1", fe_rst_n); end
    total++; if (state !== 3'd1) begin bad++; $display("FAIL wake_state got=%0d exp=1", state); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wake_busy got=%b exp=1", busy); end
    repeat (WAKE - 1) tick();
    total++; if (state !== 3'd1) begin bad++; $display("FAIL wake_hold got=%0d exp=1", state); end
    tick();
    total++; if (state !== 3'd2) begin bad++; $display("FAIL discard_entry got=%0d exp=2", state); end
    for (int i = 0; i < DISC - 1; i++) send(1'b0, 9);
    send(1'b0, 0);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL run_entry got=%0d exp=3", state); end
    total++; if (running !== 1'b1) begin bad++; $display("FAIL run_running got=%b exp=1", running); end
    repeat (9) tick();
    for (int i = 0; i < 7; i++) send(1'b1, 9);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wake_drain left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    for (int i = 0; i < 12; i++) send(i < DEPTH, 2);
    total++; if (ovf_count !== 16'd4) begin bad++; $display("FAIL bp_ovf got=%0d exp=4", ovf_count); end
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", m_valid); end
    total++; if (m_data !== 16'd11) begin bad++; $display("FAIL bp_head got=%h exp=000b", m_data); end
    // Full FIFO, read and write in the same cycle.
    m_ready = 1'b1;
    send(1'b1, 0);
    m_ready = 1'b0;
    repeat (2) tick();
    total++; if (ovf_count !== 16'd4) begin bad++; $display("FAIL full_rw_ovf got=%0d exp=4", ovf_count); end
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL full_rw_valid got=%b exp=1", m_valid); end
    send(1'b0, 2);
    total++; if (ovf_count !== 16'd5) begin bad++; $display("FAIL full_again_ovf got=%0d exp=5", ovf_count); end
    m_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    repeat (3) tick();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_drain left=%0d exp=0", exp_q.size()); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", m_valid); end
  endtask

  task automatic test_stop_drain();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b1, 2);
    // A strobe alongside stop must not be written.
    stop = 1'b1; fe_valid = 1'b1; fe_sample = next_val; next_val = next_val + 16'd1;
    tick();
    stop = 1'b0; fe_valid = 1'b0;
    total++; if (state !== 3'd4) begin bad++; $display("FAIL stop_state got=%0d exp=4", state); end
    total++; if (fe_rst_n !== 1'b0) begin bad++; $display("FAIL stop_fe_rst_n got=%b exp=0", fe_rst_n); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL stop_running got=%b exp=0", running); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL stop_busy got=%b exp=1", busy); end
    send(1'b0, 1);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      m_ready = ~m_ready;
      tick();
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL drain_left left=%0d exp=0", exp_q.size()); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", m_valid); end
    total++; if (state !== 3'd4) begin bad++; $display("FAIL drain_last got=%0d exp=4", state); end
    tick();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL drain_idle got=%0d exp=0", state); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_busy got=%b exp=0", busy); end
    m_ready = 1'b1;
  endtask

  task automatic test_stall();
    m_ready = 1'b1;
    pulse_start();
    total++; if (ovf_count !== 16'd0) begin bad++; $display("FAIL start_ovf_clr got=%0d exp=0", ovf_count); end
    repeat (WAKE) tick();
    total++; if (state !== 3'd2) begin bad++; $display("FAIL stall_discard got=%0d exp=2", state); end
    for (int i = 0; i < DISC; i++) send(1'b0, 2);
    m_ready = 1'b0;
    send(1'b1, 0);
    repeat (TMO - 1) tick();
    total++; if (state !== 3'd3) begin bad++; $display("FAIL stall_early got=%0d exp=3", state); end
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL stall_held got=%b exp=1", m_valid); end
    tick();
    total++; if (state !== 3'd5) begin bad++; $display("FAIL stall_error got=%0d exp=5", state); end
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL stall_err got=%b exp=1", err_timeout); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL stall_flush got=%b exp=0", m_valid); end
    total++; if (fe_rst_n !== 1'b0) begin bad++; $display("FAIL stall_fe_rst_n got=%b exp=0", fe_rst_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_busy got=%b exp=0", busy); end
    exp_q.delete();
    m_ready = 1'b1;
    repeat (3) tick();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL err_valid got=%b exp=0", m_valid); end
    pulse_start();
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL restart_err got=%b exp=0", err_timeout); end
    total++; if (state !== 3'd1) begin bad++; $display("FAIL restart_state got=%0d exp=1", state); end
    total++; if (fe_rst_n !== 1'b1) begin bad++; $display("FAIL restart_fe_rst_n got=%b exp=1", fe_rst_n); end
  endtask

  task automatic test_reset_discard();
    repeat (WAKE) tick();
    total++; if (state !== 3'd2) begin bad++; $display("FAIL rd_discard got=%0d exp=2", state); end
    send(1'b0, 3);
    #2;
    rst = 1'b1;
    #1;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL arst_state got=%0d exp=0", state); end
    total++; if (fe_rst_n !== 1'b0) begin bad++; $display("FAIL arst_fe_rst_n got=%b exp=0", fe_rst_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0", busy); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", m_valid); end
    total++; if (m_data !== 16'd0) begin bad++; $display("FAIL arst_data got=%h exp=0", m_data); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL startstop_state got=%0d exp=0", state); end
    total++; if (fe_rst_n !== 1'b0) begin bad++; $display("FAIL startstop_fe got=%b exp=0", fe_rst_n); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL startstop_busy got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_wake_discard();
    test_backpressure();
    test_stop_drain();
    test_stall();
    test_reset_discard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
